m9k_tensor_reader: RTL and testbench

- Initiator on the M9K word memory port: drives address/write-enable into the M9K controller and consumes its combinational read data.
- On start, parses a tensor stored at base_addr in the layout [ndims][dim0]..[dimN-1][elements...] and computes the element count as the product of the dims.
- Streams the elements out over a valid/ready interface to the compute datapath.

---
 rtl/m9k_pkg.sv | 23 ++
 rtl/m9k_controller.sv | 48 ++++
 rtl/m9k_tensor_reader.sv | 145 ++++++++++++++
 tb/tb_m9k_tensor_reader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/m9k_pkg.sv
// Shared constants and state encoding for the M9K tensor reader and the
// word memory controller it talks to.
package m9k_pkg;

   localparam int MEM_SIZE = 1024;  // memory depth in words
   localparam int ADDR_W   = 15;    // memory address width
   localparam int DATA_W   = 32;    // word width
   localparam int MAX_DIMS = 4;     // largest ndims accepted in a header

   // Index width into the physical array.
   localparam int IDX_W = $clog2(MEM_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      RD_NDIMS,
      RD_DIM,
      CHECK,
      STREAM,
      FIN,
      ERR
   } state_t;

endpackage

// File: rtl/m9k_controller.sv
// Single-port M9K word memory: registered writes, combinational reads.
// Reset (active-low, synchronous) loads a small tensor image:
//   M[0..6]  = 1, 5, 1, 2, 3, 4, 5      (1-D tensor of five elements)
//   M[7..13] = 1, 5, 6, 7, 8, 9, 10     (1-D tensor of five elements)
// Everything else reads as zero after reset. Out-of-range reads return 0,
// out-of-range writes are dropped.
module m9k_controller
   import m9k_pkg::*;
(
   input  logic              clk,
   input  logic              rst_l,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_w_en,
   input  logic [DATA_W-1:0] mem_data_store,
   output logic [DATA_W-1:0] mem_data_load
);

   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_SIZE);

   logic [DATA_W-1:0] mem [0:MEM_SIZE-1];
   logic              in_range;

   function automatic logic [DATA_W-1:0] image(input int i);
      logic [DATA_W-1:0] w;
      w = '0;
      if (i == 0 || i == 7)      w = DATA_W'(1);
      else if (i == 1 || i == 8) w = DATA_W'(5);
      else if (i >= 2 && i <= 6) w = DATA_W'(i - 1);
      else if (i >= 9 && i <= 13) w = DATA_W'(i - 3);
      return w;
   endfunction

   assign in_range = (mem_addr < MEM_LIMIT);

   // Reset reloads the image; otherwise perform in-range writes.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         for (int i = 0; i < MEM_SIZE; i++) begin
            mem[IDX_W'(i)] <= image(i);
         end
      end else if (mem_w_en && in_range) begin
         mem[mem_addr[IDX_W-1:0]] <= mem_data_store;
      end
   end

   assign mem_data_load = in_range ? mem[mem_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/m9k_tensor_reader.sv
// Reads a tensor header [ndims][dim0]..[dimN-1] from M9K memory, validates
// it, and streams the element words out over valid/ready.
//
// Handshake: out_valid is held high in STREAM until out_ready is seen high
// on a rising edge; an element transfers exactly on a cycle where both are
// high. While out_ready is low the address, and therefore out_data, stay put.
module m9k_tensor_reader
   import m9k_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       num_elems,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_w_en,
   output logic [DATA_W-1:0] mem_data_store,
   input  logic [DATA_W-1:0] mem_data_load,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output state_t            fsm_state
);

   localparam int AW1 = ADDR_W + 1;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base_q;
   logic [2:0]        ndims_q;
   logic [2:0]        dims_left;
   logic [31:0]       acc;
   logic [31:0]       idx;
   logic [63:0]       product;
   logic [AW1-1:0]    end_addr;
   logic              ndims_bad;
   logic              dim_bad;
   logic              bound_bad;
   logic              hs;
   logic              last;

   // Header validation terms, all evaluated against the word on the bus.
   assign ndims_bad = (mem_data_load == '0) || (mem_data_load > DATA_W'(MAX_DIMS));
   assign product   = 64'(acc) * 64'(mem_data_load);
   assign dim_bad   = (mem_data_load == '0) || (product[63:32] != '0) ||
                      (product[31:0] > 32'(MEM_SIZE));
   // One past the last element; acc never exceeds MEM_SIZE so the slice is exact.
   assign end_addr  = AW1'(base_q) + AW1'(1) + AW1'(ndims_q) + acc[AW1-1:0];
   assign bound_bad = (end_addr > AW1'(MEM_SIZE));

   assign hs   = (state == STREAM) && out_ready;
   assign last = (idx == num_elems - 32'd1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = RD_NDIMS;
         RD_NDIMS: state_nxt = ndims_bad ? ERR : RD_DIM;
         RD_DIM: begin
            if (dim_bad)                state_nxt = ERR;
            else if (dims_left == 3'd1) state_nxt = CHECK;
         end
         CHECK:    state_nxt = bound_bad ? ERR : STREAM;
         STREAM:   if (hs && last) state_nxt = FIN;
         FIN:      state_nxt = IDLE;
         ERR:      state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Datapath: address walk, dim product, element counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q    <= '0;
         ndims_q   <= '0;
         dims_left <= '0;
         acc       <= '0;
         idx       <= '0;
         num_elems <= '0;
         mem_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_q    <= base_addr;
                  mem_addr  <= base_addr;
                  num_elems <= '0;
               end
            end
            RD_NDIMS: begin
               if (!ndims_bad) begin
                  ndims_q   <= mem_data_load[2:0];
                  dims_left <= mem_data_load[2:0];
                  acc       <= 32'd1;
                  mem_addr  <= mem_addr + ADDR_W'(1);
               end
            end
            RD_DIM: begin
               if (!dim_bad) begin
                  acc       <= product[31:0];
                  dims_left <= dims_left - 3'd1;
                  mem_addr  <= mem_addr + ADDR_W'(1);
               end
            end
            CHECK: begin
               if (!bound_bad) begin
                  num_elems <= acc;
                  idx       <= '0;
               end
            end
            STREAM: begin
               // The final handshake leaves mem_addr on the last element so
               // it never steps past the end of memory.
               if (hs && !last) begin
                  idx      <= idx + 32'd1;
                  mem_addr <= mem_addr + ADDR_W'(1);
               end
            end
            ERR:     num_elems <= '0;
            default: ;
         endcase
      end
   end

   assign busy           = (state != IDLE);
   assign done           = (state == FIN) || (state == ERR);
   assign err            = (state == ERR);
   assign out_valid      = (state == STREAM);
   assign out_last       = (state == STREAM) && last;
   assign out_data       = (state == STREAM) ? mem_data_load : '0;
   assign mem_w_en       = 1'b0;
   assign mem_data_store = '0;
   assign fsm_state      = state;

endmodule

// File: tb/tb_m9k_tensor_reader.sv
// Directed bench for m9k_tensor_reader wired to m9k_controller.
module tb_m9k_tensor_reader;
   import m9k_pkg::*;

   localparam int BUDGET = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              busy, done, err;
   logic [31:0]       num_elems;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_w_en;
   logic [DATA_W-1:0] mem_data_store, mem_data_load;
   logic [DATA_W-1:0] out_data;
   logic              out_valid, out_last;
   logic              out_ready = 1'b1;
   state_t            fsm_state;

   // Bench-side preload port, muxed onto the controller while the reader idles.
   logic              tb_load = 1'b0;
   logic              tb_wen = 1'b0;
   logic [ADDR_W-1:0] tb_addr = '0;
   logic [DATA_W-1:0] tb_wdata = '0;
   logic [ADDR_W-1:0] ctrl_addr;
   logic              ctrl_wen;
   logic [DATA_W-1:0] ctrl_wdata;

   int errors = 0;
   int checks = 0;

   assign ctrl_addr  = tb_load ? tb_addr  : mem_addr;
   assign ctrl_wen   = tb_load ? tb_wen   : mem_w_en;
   assign ctrl_wdata = tb_load ? tb_wdata : mem_data_store;

   m9k_tensor_reader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .err(err), .num_elems(num_elems),
      .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_data_store(mem_data_store),
      .mem_data_load(mem_data_load), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .fsm_state(fsm_state)
   );

   m9k_controller ctrl (
      .clk(clk), .rst_l(~rst), .mem_addr(ctrl_addr), .mem_w_en(ctrl_wen),
      .mem_data_store(ctrl_wdata), .mem_data_load(mem_data_load)
   );

   // Clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] base;
      logic [15:0]       ready_pat;  // out_ready per STREAM cycle, LSB first
      logic              exp_err;
      logic [31:0]       exp_num;
      logic [31:0]       exp_first;  // elements are consecutive from here
      int                exp_lat;    // cycle of first out_valid (start = cycle 0)
      int                exp_done;   // cycle of the done pulse
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input int base, input logic [15:0] pat, input logic e,
                               input int num, input int first, input int lat, input int dn);
      vec_t v;
      v.base = ADDR_W'(base); v.ready_pat = pat; v.exp_err = e;
      v.exp_num = 32'(num); v.exp_first = 32'(first); v.exp_lat = lat; v.exp_done = dn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic write_mem(input int addr, input int data);
      @(negedge clk);
      tb_load = 1'b1; tb_wen = 1'b1; tb_addr = ADDR_W'(addr); tb_wdata = DATA_W'(data);
      @(negedge clk);
      tb_wen = 1'b0; tb_load = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int s, got, first_cyc, done_cyc;
      logic held, wen_seen, err_at_done;
      logic [DATA_W-1:0] held_data;
      logic [ADDR_W-1:0] held_addr;
      logic [31:0] ne;
      s = 0; got = 0; first_cyc = -1; done_cyc = -1;
      held = 1'b0; wen_seen = 1'b0; err_at_done = 1'b0; ne = '0;
      held_data = '0; held_addr = '0;
      @(negedge clk);
      start = 1'b1; base_addr = v.base; out_ready = v.ready_pat[0];
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc < BUDGET; cyc++) begin
         out_ready = v.ready_pat[s % 16];
         if (mem_w_en) wen_seen = 1'b1;
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (held) begin
               chk("stall_data", out_data, held_data);
               chk("stall_addr", 32'(mem_addr), 32'(held_addr));
            end
            if (out_ready) begin
               chk("elem", out_data, v.exp_first + 32'(got));
               chk("out_last", 32'(out_last), 32'(got == int'(v.exp_num) - 1));
               got++;
               held = 1'b0;
            end else begin
               held = 1'b1; held_data = out_data; held_addr = mem_addr;
            end
            s++;
         end
         if (done) begin
            done_cyc = cyc; err_at_done = err; ne = num_elems;
            break;
         end
         @(negedge clk);
      end
      if (done_cyc < 0) chk("done_timeout", 32'(done_cyc), 32'(v.exp_done));
      chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
      chk("err_at_done", 32'(err_at_done), 32'(v.exp_err));
      chk("num_at_done", ne, v.exp_num);
      chk("accepted", 32'(got), v.exp_num);
      chk("mem_w_en", 32'(wen_seen), 32'd0);
      if (v.exp_err) chk("valid_on_err", 32'(first_cyc >= 0), 32'd0);
      else           chk("first_valid", 32'(first_cyc), 32'(v.exp_lat));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("num_held", num_elems, v.exp_num);
      out_ready = 1'b1;
   endtask

   initial begin
      vecs[0] = mk(0,    16'hFFFF, 1'b0, 5, 1,  4, 9);
      vecs[1] = mk(7,    16'hFFFF, 1'b0, 5, 6,  4, 9);
      vecs[2] = mk(0,    16'hFF69, 1'b0, 5, 1,  4, 13);
      vecs[3] = mk(20,   16'hFFFF, 1'b0, 6, 11, 5, 11);
      vecs[4] = mk(30,   16'hFFFF, 1'b1, 0, 0,  0, 2);
      vecs[5] = mk(40,   16'hFFFF, 1'b1, 0, 0,  0, 2);
      vecs[6] = mk(50,   16'hFFFF, 1'b1, 0, 0,  0, 3);
      vecs[7] = mk(1010, 16'hFFFF, 1'b1, 0, 0,  0, 4);

      // Reset.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_num", num_elems, 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_data_store", mem_data_store, 0);

      // Headers for the preloaded and malformed tensors.
      write_mem(20, 2); write_mem(21, 2); write_mem(22, 3);
      for (int i = 0; i < 6; i++) write_mem(23 + i, 11 + i);
      write_mem(30, 0);
      write_mem(40, 5);
      write_mem(50, 1); write_mem(51, 2000);
      write_mem(1010, 1); write_mem(1011, 20);

      for (int k = 0; k < 8; k++) run_vec(vecs[k]);

      // Reset in the middle of a stream abandons it without a done pulse.
      @(negedge clk);
      start = 1'b1; base_addr = '0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_valid", 32'(out_valid), 1);
      chk("mid_data", out_data, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_err", 32'(err), 0);
      chk("mrst_num", num_elems, 0);
      chk("mrst_addr", 32'(mem_addr), 0);
      chk("mrst_valid", 32'(out_valid), 0);
      chk("mrst_last", 32'(out_last), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mrst_no_done", 32'(done), 0);
      end
      run_vec(vecs[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
